// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer slice: opcodes, FSM states,
// and per-opcode depth rules (minimum depth needed and depth change on store).
// No logic of its own; imported by stack_guard and stack_sequencer.
package stack_pkg;

   // Stack operation codes as seen on i_req_op and o_stk_function
   localparam logic [2:0] OP_PUSH   = 3'd0;
   localparam logic [2:0] OP_D1PUSH = 3'd1;
   localparam logic [2:0] OP_D2PUSH = 3'd2;
   localparam logic [2:0] OP_SWAP   = 3'd3;
   localparam logic [2:0] OP_DROP   = 3'd4;
   localparam logic [2:0] OP_DROP2  = 3'd5;
   localparam logic [2:0] OP_ROLL   = 3'd6;
   localparam logic [2:0] OP_PEEK   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_STORE   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   // Entries that must already be on the stack. PUSH is bounded by capacity
   // instead, which depends on DEPTH and is checked in stack_guard.
   function automatic int min_depth(input logic [2:0] op);
      case (op)
         OP_D1PUSH: return 1;
         OP_D2PUSH: return 2;
         OP_SWAP:   return 2;
         OP_DROP:   return 1;
         OP_DROP2:  return 2;
         OP_ROLL:   return 3;
         default:   return 0;
      endcase
   endfunction

   // Net change in stack depth once the op is stored
   function automatic int depth_delta(input logic [2:0] op);
      case (op)
         OP_PUSH:   return 1;
         OP_D2PUSH: return -1;
         OP_DROP:   return -1;
         OP_DROP2:  return -2;
         default:   return 0;
      endcase
   endfunction

   // Ops whose stack-side implementation needs the top entries latched first
   function automatic logic needs_fetch(input logic [2:0] op);
      return (op == OP_SWAP) || (op == OP_ROLL) || (op == OP_PEEK);
   endfunction

endpackage

// File: rtl/stack_guard.sv
// Purpose: shadow stack-depth register plus combinational legality check.
// Latency: legality is combinational on chk_op; depth updates one edge after upd_en.
// Backpressure: none; the sequencer only asks when it is able to act on the answer.
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset (depth -> 0)
//   chk_op        opcode of the request being offered
//   chk_legal     1 when chk_op would neither underflow nor overflow
//   upd_en        pulse in the cycle the op is stored into the stack
//   upd_op        opcode being stored (selects the depth change)
module stack_guard
   import stack_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [2:0] chk_op,
   output logic       chk_legal,
   input  logic       upd_en,
   input  logic [2:0] upd_op
);

   localparam int DW = $clog2(DEPTH);

   logic [DW-1:0] depth_q;

   // Usable capacity is DEPTH-1: the stack's own pointer would wrap at DEPTH.
   always_comb begin
      if (chk_op == OP_PUSH) begin
         chk_legal = int'(depth_q) < (DEPTH - 1);
      end else begin
         chk_legal = int'(depth_q) >= min_depth(chk_op);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         depth_q <= '0;
      end else if (upd_en) begin
         depth_q <= DW'(int'(depth_q) + depth_delta(upd_op));
      end
   end

endmodule

// File: rtl/stack_sequencer.sv
// Purpose: initiator-side controller that turns one stack op into fetch/store strobes.
// Latency: error 1, PUSH/D1PUSH/D2PUSH/DROP/DROP2 2, SWAP/ROLL 3, PEEK 4 cycles to o_rsp_valid.
// Backpressure: one op in flight; o_req_ready only in IDLE, response held until i_rsp_ready.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_req_valid/o_req_ready            request handshake
//   i_req_op, i_req_data               opcode and operand D
//   o_rsp_valid/i_rsp_ready            response handshake
//   o_rsp_error                        request rejected (underflow/overflow)
//   o_rsp_A, o_rsp_B                   top two stack entries (PEEK, else 0)
//   o_stk_fetch, o_stk_store           stack strobes, never high together
//   o_stk_function, o_stk_write_D      stack op and data, zero unless storing
//   i_stk_read_A, i_stk_read_B         stack top-entry outputs
//
// Optional build macro STACK_SEQ_AUTOPEEK_EN: every legal non-PEEK op is
// followed by an internal FETCH + PEEK store + CAPTURE, so each response
// carries the new top A/B (3 extra cycles).
module stack_sequencer
   import stack_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [2:0]       i_req_op,
   input  logic [WIDTH-1:0] i_req_data,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic             o_rsp_error,
   output logic [WIDTH-1:0] o_rsp_A,
   output logic [WIDTH-1:0] o_rsp_B,
   output logic             o_stk_fetch,
   output logic             o_stk_store,
   output logic [2:0]       o_stk_function,
   output logic [WIDTH-1:0] o_stk_write_D,
   input  logic [WIDTH-1:0] i_stk_read_A,
   input  logic [WIDTH-1:0] i_stk_read_B
);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] rsp_a_q, rsp_a_d;
   logic [WIDTH-1:0] rsp_b_q, rsp_b_d;
   logic             legal;
   logic             depth_upd;

   stack_guard #(
      .DEPTH (DEPTH)
   ) u_guard (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .chk_op    (i_req_op),
      .chk_legal (legal),
      .upd_en    (depth_upd),
      .upd_op    (op_q)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         rsp_a_q <= '0;
         rsp_b_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         err_q   <= err_d;
         rsp_a_q <= rsp_a_d;
         rsp_b_q <= rsp_b_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      data_d         = data_q;
      err_d          = err_q;
      rsp_a_d        = rsp_a_q;
      rsp_b_d        = rsp_b_q;
      depth_upd      = 1'b0;
      o_req_ready    = 1'b0;
      o_rsp_valid    = 1'b0;
      o_rsp_error    = 1'b0;
      o_rsp_A        = '0;
      o_rsp_B        = '0;
      o_stk_fetch    = 1'b0;
      o_stk_store    = 1'b0;
      o_stk_function = '0;
      o_stk_write_D  = '0;

      case (state_q)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               op_d    = i_req_op;
               data_d  = i_req_data;
               err_d   = !legal;
               rsp_a_d = '0;
               rsp_b_d = '0;
               // Illegal requests never touch the stack
               if (!legal) begin
                  state_d = ST_RESP;
               end else if (needs_fetch(i_req_op)) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_STORE;
               end
            end
         end

         ST_FETCH: begin
            o_stk_fetch = 1'b1;
            state_d     = ST_STORE;
         end

         ST_STORE: begin
            o_stk_store    = 1'b1;
            o_stk_function = op_q;
            o_stk_write_D  = data_q;
            depth_upd      = 1'b1;
            if (op_q == OP_PEEK) begin
               state_d = ST_CAPTURE;
            end else begin
`ifdef STACK_SEQ_AUTOPEEK_EN
               // Reuse the PEEK path; PEEK leaves depth unchanged on its store
               op_d    = OP_PEEK;
               state_d = ST_FETCH;
`else
               state_d = ST_RESP;
`endif
            end
         end

         ST_CAPTURE: begin
            // Stack outputs settle one cycle after the PEEK store
            rsp_a_d = i_stk_read_A;
            rsp_b_d = i_stk_read_B;
            state_d = ST_RESP;
         end

         ST_RESP: begin
            o_rsp_valid = 1'b1;
            o_rsp_error = err_q;
            o_rsp_A     = rsp_a_q;
            o_rsp_B     = rsp_b_q;
            if (i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural data-stack model.
// The model latches the top two entries on fetch and applies the function on store.
// Responses are accepted one cycle after they appear unless a step holds them.
module tb_stack_sequencer;

   localparam logic [2:0] PUSH   = 3'd0;
   localparam logic [2:0] D1PUSH = 3'd1;
   localparam logic [2:0] D2PUSH = 3'd2;
   localparam logic [2:0] SWAP   = 3'd3;
   localparam logic [2:0] DROP   = 3'd4;
   localparam logic [2:0] DROP2  = 3'd5;
   localparam logic [2:0] ROLL   = 3'd6;
   localparam logic [2:0] PEEK   = 3'd7;
   localparam logic [15:0] EMPTY = 16'hDEAD;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic [2:0]  i_req_op = 3'd0;
   logic [15:0] i_req_data = 16'd0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic        o_rsp_error;
   logic [15:0] o_rsp_A, o_rsp_B;
   logic        o_stk_fetch, o_stk_store;
   logic [2:0]  o_stk_function;
   logic [15:0] o_stk_write_D;
   logic [15:0] i_stk_read_A, i_stk_read_B;

   int errors = 0;
   int checks = 0;

   always #5 i_clk = ~i_clk;

   stack_sequencer #(.WIDTH(16), .DEPTH(8)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_op       (i_req_op),
      .i_req_data     (i_req_data),
      .o_rsp_valid    (o_rsp_valid),
      .i_rsp_ready    (i_rsp_ready),
      .o_rsp_error    (o_rsp_error),
      .o_rsp_A        (o_rsp_A),
      .o_rsp_B        (o_rsp_B),
      .o_stk_fetch    (o_stk_fetch),
      .o_stk_store    (o_stk_store),
      .o_stk_function (o_stk_function),
      .o_stk_write_D  (o_stk_write_D),
      .i_stk_read_A   (i_stk_read_A),
      .i_stk_read_B   (i_stk_read_B)
   );

   // ---------------- behavioural data stack ----------------
   logic [15:0] mem [0:7];
   int          sp;
   logic [15:0] a_reg, b_reg;

   assign i_stk_read_A = a_reg;
   assign i_stk_read_B = b_reg;

   function automatic logic [15:0] rd(input int idx);
      if (idx >= 0 && idx < sp) return mem[3'(idx)];
      return EMPTY;
   endfunction

   always @(posedge i_clk) begin
      if (i_rst) begin
         sp    <= 0;
         a_reg <= EMPTY;
         b_reg <= EMPTY;
      end else begin
         if (o_stk_fetch) begin
            a_reg <= rd(sp - 1);
            b_reg <= rd(sp - 2);
         end
         if (o_stk_store) begin
            case (o_stk_function)
               PUSH:   begin mem[3'(sp)] <= o_stk_write_D; sp <= sp + 1; end
               D1PUSH: mem[3'(sp - 1)] <= o_stk_write_D;
               D2PUSH: begin mem[3'(sp - 2)] <= o_stk_write_D; sp <= sp - 1; end
               SWAP:   begin mem[3'(sp - 1)] <= b_reg; mem[3'(sp - 2)] <= a_reg; end
               DROP:   sp <= sp - 1;
               DROP2:  sp <= sp - 2;
               ROLL: begin
                  mem[3'(sp - 1)] <= b_reg;
                  mem[3'(sp - 2)] <= mem[3'(sp - 3)];
                  mem[3'(sp - 3)] <= a_reg;
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- strobe monitor ----------------
   int   fetch_cnt = 0, store_cnt = 0, overlap_cnt = 0, stray_cnt = 0;
   logic prev_fetch = 1'b0;
   logic store_after_fetch = 1'b0;

   always @(negedge i_clk) begin
      if (o_stk_fetch) fetch_cnt++;
      if (o_stk_store) begin
         store_cnt++;
         store_after_fetch = prev_fetch;
      end
      if (o_stk_fetch && o_stk_store) overlap_cnt++;
      if (!o_stk_store && (o_stk_function != 3'd0 || o_stk_write_D != 16'd0)) stray_cnt++;
      prev_fetch = o_stk_fetch;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   // Issue one op, check latency/response/strobes, then accept the response
   task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] d,
                        input logic exp_err, input int exp_lat,
                        input logic [15:0] exp_a, input logic [15:0] exp_b);
      int   lat;
      int   w;
      int   f0, s0;
      logic exp_fetch;
      exp_fetch = !exp_err && (op == SWAP || op == ROLL || op == PEEK);
      w = 0;
      @(negedge i_clk);
      while (!o_req_ready && w < 20) begin
         @(negedge i_clk);
         w++;
      end
      check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
      f0 = fetch_cnt;
      s0 = store_cnt;
      i_req_valid = 1'b1;
      i_req_op    = op;
      i_req_data  = d;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      i_req_op    = 3'd0;
      i_req_data  = 16'd0;
      lat = 1;
      while (!o_rsp_valid && lat < 30) begin
         @(posedge i_clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_error"}, 32'(o_rsp_error), 32'(exp_err));
      check({tag, "_A"}, 32'(o_rsp_A), 32'(exp_a));
      check({tag, "_B"}, 32'(o_rsp_B), 32'(exp_b));
      i_rsp_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_rsp_ready = 1'b0;
      check({tag, "_fetch_pulses"}, 32'(fetch_cnt - f0), 32'(exp_fetch));
      check({tag, "_store_pulses"}, 32'(store_cnt - s0), exp_err ? 32'd0 : 32'd1);
      if (!exp_err) check({tag, "_fetch_before_store"}, 32'(store_after_fetch), 32'(exp_fetch));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [15:0] held_a, held_b;
      logic        held_e;

      do_reset();
      #1;
      check("reset_req_ready", 32'(o_req_ready), 32'd1);
      check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("reset_rsp_error", 32'(o_rsp_error), 32'd0);
      check("reset_rsp_A", 32'(o_rsp_A), 32'd0);
      check("reset_rsp_B", 32'(o_rsp_B), 32'd0);
      check("reset_fetch", 32'(o_stk_fetch), 32'd0);
      check("reset_store", 32'(o_stk_store), 32'd0);
      check("reset_function", 32'(o_stk_function), 32'd0);
      check("reset_write_D", 32'(o_stk_write_D), 32'd0);
      check("reset_depth", 32'(dut.u_guard.depth_q), 32'd0);

      // 1: push two, peek
      do_op("t1_push1", PUSH, 16'h1111, 1'b0, 2, 16'h0, 16'h0);
      do_op("t1_push2", PUSH, 16'h2222, 1'b0, 2, 16'h0, 16'h0);
      do_op("t1_peek", PEEK, 16'h0, 1'b0, 4, 16'h2222, 16'h1111);

      // 2: swap, peek
      do_op("t2_swap", SWAP, 16'h0, 1'b0, 3, 16'h0, 16'h0);
      do_op("t2_peek", PEEK, 16'h0, 1'b0, 4, 16'h1111, 16'h2222);

      // 3: underflow rejection
      do_reset();
      do_op("t3_drop_empty", DROP, 16'h0, 1'b1, 1, 16'h0, 16'h0);
      check("t3_depth_after_drop", 32'(dut.u_guard.depth_q), 32'd0);
      do_op("t3_push", PUSH, 16'h0005, 1'b0, 2, 16'h0, 16'h0);
      do_op("t3_d2push_depth1", D2PUSH, 16'h0009, 1'b1, 1, 16'h0, 16'h0);
      check("t3_depth_after_d2push", 32'(dut.u_guard.depth_q), 32'd1);

      // 4: fill to capacity, overflow, peek
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         do_op("t4_fill", PUSH, 16'(i), 1'b0, 2, 16'h0, 16'h0);
      end
      do_op("t4_push8", PUSH, 16'h0008, 1'b1, 1, 16'h0, 16'h0);
      check("t4_depth_full", 32'(dut.u_guard.depth_q), 32'd7);
      do_op("t4_peek", PEEK, 16'h0, 1'b0, 4, 16'h0007, 16'h0006);

      // 5: roll, drop2, replace-top ops
      do_reset();
      do_op("t5_pushA", PUSH, 16'h000A, 1'b0, 2, 16'h0, 16'h0);
      do_op("t5_pushB", PUSH, 16'h000B, 1'b0, 2, 16'h0, 16'h0);
      do_op("t5_pushC", PUSH, 16'h000C, 1'b0, 2, 16'h0, 16'h0);
      do_op("t5_roll", ROLL, 16'h0, 1'b0, 3, 16'h0, 16'h0);
      do_op("t5_peek_roll", PEEK, 16'h0, 1'b0, 4, 16'h000B, 16'h000A);
      do_op("t5_drop2", DROP2, 16'h0, 1'b0, 2, 16'h0, 16'h0);
      do_op("t5_peek_drop2", PEEK, 16'h0, 1'b0, 4, 16'h000C, EMPTY);
      do_op("t5_d1push", D1PUSH, 16'h00D1, 1'b0, 2, 16'h0, 16'h0);
      do_op("t5_pushE", PUSH, 16'h000E, 1'b0, 2, 16'h0, 16'h0);
      do_op("t5_d2push", D2PUSH, 16'h000F, 1'b0, 2, 16'h0, 16'h0);
      check("t5_depth", 32'(dut.u_guard.depth_q), 32'd1);

      // 6a: response held for 5 cycles
      @(negedge i_clk);
      i_req_valid = 1'b1;
      i_req_op    = PEEK;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      i_req_op    = 3'd0;
      repeat (3) @(posedge i_clk);
      #1;
      check("t6_hold_first_valid", 32'(o_rsp_valid), 32'd1);
      held_a = o_rsp_A;
      held_b = o_rsp_B;
      held_e = o_rsp_error;
      check("t6_hold_A", 32'(held_a), 32'h000F);
      check("t6_hold_B", 32'(held_b), 32'(EMPTY));
      for (int c = 0; c < 5; c++) begin
         @(posedge i_clk);
         #1;
         check("t6_hold_valid", 32'(o_rsp_valid), 32'd1);
         check("t6_hold_A_stable", 32'(o_rsp_A), 32'(held_a));
         check("t6_hold_B_stable", 32'(o_rsp_B), 32'(held_b));
         check("t6_hold_err_stable", 32'(o_rsp_error), 32'(held_e));
         check("t6_hold_req_ready", 32'(o_req_ready), 32'd0);
      end
      i_rsp_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_rsp_ready = 1'b0;
      check("t6_after_accept_valid", 32'(o_rsp_valid), 32'd0);
      check("t6_after_accept_ready", 32'(o_req_ready), 32'd1);

      // 6b: reset while in STORE
      @(negedge i_clk);
      i_req_valid = 1'b1;
      i_req_op    = PUSH;
      i_req_data  = 16'h0077;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      i_req_data  = 16'h0;
      check("t6_in_store", 32'(o_stk_store), 32'd1);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      check("t6_rst_store", 32'(o_stk_store), 32'd0);
      check("t6_rst_fetch", 32'(o_stk_fetch), 32'd0);
      check("t6_rst_function", 32'(o_stk_function), 32'd0);
      check("t6_rst_req_ready", 32'(o_req_ready), 32'd1);
      check("t6_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("t6_rst_depth", 32'(dut.u_guard.depth_q), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      do_op("t6_peek_empty", PEEK, 16'h0, 1'b0, 4, EMPTY, EMPTY);

      check("strobe_overlap", 32'(overlap_cnt), 32'd0);
      check("stray_function_data", 32'(stray_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
Initiator-side controller for the CPU data stack. Accepts one high-level stack operation at a time from instruction decode over a valid/ready handshake. Drives the stack's fetch/store/function/write-data strobes in the required order and returns the top two entries for PEEK. Tracks stack depth itself and rejects underflow/overflow before any stack access is made.

Parameters:
WIDTH, 16, data word width; must match the stack.
DEPTH, 8, stack array depth; usable capacity is DEPTH-1 because the stack pointer is $clog2(DEPTH) bits wide and would wrap at DEPTH.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req_valid  in  1  request valid
o_req_ready  out  1  high only in IDLE
i_req_op  in  3  opcode: PUSH=0 D1PUSH=1 D2PUSH=2 SWAP=3 DROP=4 DROP2=5 ROLL=6 PEEK=7
i_req_data  in  WIDTH  operand D for PUSH/D1PUSH/D2PUSH
o_rsp_valid  out  1  response valid, held until accepted
i_rsp_ready  in  1  response accept
o_rsp_error  out  1  request rejected (underflow/overflow)
o_rsp_A  out  WIDTH  top of stack (PEEK only, else 0)
o_rsp_B  out  WIDTH  second entry (PEEK only, else 0)
o_stk_fetch  out  1  stack fetch strobe
o_stk_store  out  1  stack store strobe
o_stk_function  out  3  stack function code
o_stk_write_D  out  WIDTH  stack write data
i_stk_read_A  in  WIDTH  stack A output
i_stk_read_B  in  WIDTH  stack B output

Behaviour:
- Reset (i_rst high at posedge): state=IDLE, depth=0, all outputs 0 except o_req_ready=1. A reset in any state aborts the operation with no further strobes. The stack is reset by the same i_rst.
- Depth counter: $clog2(DEPTH) bits.
- Minimum depth required per opcode: PUSH needs depth<DEPTH-1; D1PUSH 1; D2PUSH 2; SWAP 2; DROP 1; DROP2 2; ROLL 3; PEEK 0.
- Depth change per opcode: PUSH +1; D2PUSH, DROP -1; DROP2 -2; all others unchanged.
- Depth is updated in the STORE cycle.
- States:
  - IDLE: on valid&ready, latch op/data.
    - Illegal request -> RESP with error=1; no fetch/store pulse.
    - SWAP/ROLL/PEEK -> FETCH.
    - All other opcodes -> STORE.
  - FETCH: o_stk_fetch=1 for exactly one cycle -> STORE.
  - STORE: o_stk_store=1 for one cycle, with o_stk_function=op and o_stk_write_D=data. PEEK -> CAPTURE; all others -> RESP.
  - CAPTURE: the stack outputs are now valid; register them into o_rsp_A/B -> RESP.
  - RESP: o_rsp_valid=1, with data and error stable. When i_rsp_ready=1 -> IDLE.
- Strobe rules:
  - fetch and store are never high in the same cycle.
  - o_stk_function and o_stk_write_D are 0 when store=0.
- Latency (accept edge to first o_rsp_valid cycle):
  - Error: 1 cycle.
  - PUSH/D1PUSH/D2PUSH/DROP/DROP2: 2 cycles.
  - SWAP/ROLL: 3 cycles.
  - PEEK: 4 cycles.
- Back-to-back: minimum 1 IDLE cycle between responses; no pipelining.
- At depth 0, PEEK returns whatever the stack outputs (its empty-fill value 0xDEAD); error=0.

Optional Feature:
- STACK_SEQ_AUTOPEEK_EN defined: after STORE of any non-PEEK legal op, the block inserts FETCH, then a PEEK store, then CAPTURE before RESP. Every legal response then carries the new top A/B, and latency grows by 3 cycles.
- Undefined: o_rsp_A/B are 0 for non-PEEK ops.

Decomposition:
- Shared package stack_pkg holds:
  - Opcode localparams (PUSH..PEEK).
  - Per-opcode min-depth and depth-delta constants.
  - State encoding (IDLE, FETCH, STORE, CAPTURE, RESP).
- One sub-module, stack_guard (combinational legality check plus depth register), is natural.
- The FSM lives in stack_sequencer, paired with the existing stack model in the bench.

Test Plan:
1. Reset; PUSH 0x1111, PUSH 0x2222, PEEK -> rsp A=0x2222 B=0x1111 error=0. PEEK o_rsp_valid appears 4 cycles after accept; PUSH responses after 2.
2. Continue with SWAP, then PEEK -> A=0x1111 B=0x2222. o_stk_fetch is high exactly the cycle before o_stk_store.
3. After reset, DROP -> error=1 one cycle after accept, no fetch/store pulse, depth stays 0. Then D2PUSH with depth 1 -> error=1.
4. PUSH 1..7 all error=0; 8th PUSH 0x0008 -> error=1; PEEK -> A=0x0007 B=0x0006.
5. PUSH 0x000A, 0x000B, 0x000C; ROLL; PEEK -> A=0x000B B=0x000A. DROP2 then PEEK -> A=0x000C.
6. Hold i_rsp_ready=0 for 5 cycles: o_rsp_valid/data stable, o_req_ready=0. Separately, assert i_rst during the STORE state: next cycle IDLE, all strobes 0, depth 0.
